// File: rtl/tiny_cpu_uart_tx.sv
// UART transmit stage for the tiny CPU output port: byte FIFO feeding an 8N1 serializer.
// Define TINYCPU_UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module tiny_cpu_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_full,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

`ifdef TINYCPU_UART_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;

  state_t           state_reg;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_idx_reg;
  logic [15:0]      baud_reg;
  logic             tx_reg;
`ifdef TINYCPU_UART_PARITY_EN
  logic             parity_reg;
`endif

  logic fifo_empty;
  logic push;
  logic pop;
  logic baud_done;

  assign fifo_empty = (count_reg == '0);
  assign wr_full    = (count_reg == FULL_CNT);
  assign push       = wr_valid && !wr_full;
  assign pop        = (state_reg == ST_IDLE) && !fifo_empty;
  assign baud_done  = (baud_reg == BAUD_LAST);

  assign tx       = tx_reg;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != ST_IDLE) || !fifo_empty;

  // Storage has no reset so it can map onto distributed/block memory.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      // Fullness is judged on the pre-edge count, so a same-cycle pop does not rescue the write.
      if (wr_valid && wr_full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // tx_reg is loaded with the level of the state being entered, keeping tx a pure flop output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      baud_reg    <= '0;
      tx_reg      <= 1'b1;
`ifdef TINYCPU_UART_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shift_reg   <= fifo_mem[rd_ptr_reg];
`ifdef TINYCPU_UART_PARITY_EN
            parity_reg  <= ^fifo_mem[rd_ptr_reg];
`endif
            bit_idx_reg <= '0;
            baud_reg    <= '0;
            tx_reg      <= 1'b0;
            state_reg   <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_reg  <= '0;
            tx_reg    <= shift_reg[0];
            state_reg <= ST_DATA;
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_reg    <= '0;
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
`ifdef TINYCPU_UART_PARITY_EN
              tx_reg    <= parity_reg;
              state_reg <= ST_PARITY;
`else
              tx_reg    <= 1'b1;
              state_reg <= ST_STOP;
`endif
            end else begin
              tx_reg <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
`ifdef TINYCPU_UART_PARITY_EN
        ST_PARITY: begin
          if (baud_done) begin
            baud_reg  <= '0;
            tx_reg    <= 1'b1;
            state_reg <= ST_STOP;
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (baud_done) begin
            baud_reg  <= '0;
            state_reg <= ST_IDLE;
          end else begin
            baud_reg <= baud_reg + 16'd1;
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          baud_reg  <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_cpu_uart_tx.sv
// Directed bench for tiny_cpu_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Build with TINYCPU_UART_PARITY_EN defined to check 8E1 frames.
module tb_tiny_cpu_uart_tx;

  localparam int CPB = 4;
`ifdef TINYCPU_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_full;
  logic       tx;
  logic       busy;
  logic       overflow;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs [9];

  tiny_cpu_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .wr_full (wr_full),
    .tx      (tx),
    .busy    (busy),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: act=%0h exp=%0h", name, $time, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    $display("write 0x%02h: wr_full=%0b overflow=%0b busy=%0b", d, wr_full, overflow, busy);
  endtask

  // Checks tx for every cycle of a frame from cycle offset 'start'; optionally injects a write at cycle inj_k.
  task automatic frame_body(input logic [7:0] d, input logic p, input int start,
                            input int inj_k, input logic [7:0] inj_d);
    logic [10:0] bits;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (NB == 11) bits[9] = p;
    for (int k = start; k < NB * CPB; k++) begin
      chk("frame_tx", {7'b0, tx}, {7'b0, bits[k / CPB]});
      chk("frame_busy", {7'b0, busy}, 8'd1);
      if (k == inj_k) begin
        wr_valid = 1'b1;
        wr_data  = inj_d;
      end
      tick();
      wr_valid = 1'b0;
    end
    $display("frame 0x%02h done: tx=%0b busy=%0b", d, tx, busy);
  endtask

  task automatic frame(input logic [7:0] d, input logic p);
    chk("idle_gap_tx", {7'b0, tx}, 8'd1);
    tick();
    frame_body(d, p, 0, -1, 8'h00);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h01, 1'b1};
    vecs[2] = '{8'h80, 1'b1};
    vecs[3] = '{8'h7F, 1'b1};
    vecs[4] = '{8'h3C, 1'b0};
    vecs[5] = '{8'hFF, 1'b0};
    vecs[6] = '{8'h00, 1'b0};
    vecs[7] = '{8'hC3, 1'b0};
    vecs[8] = '{8'h5B, 1'b1};

    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    tick();
    tick();
    chk("rst_tx", {7'b0, tx}, 8'd1);
    chk("rst_busy", {7'b0, busy}, 8'd0);
    chk("rst_full", {7'b0, wr_full}, 8'd0);
    chk("rst_ovf", {7'b0, overflow}, 8'd0);
    reset = 1'b0;

    // Quiet period: nothing must move without a write.
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("quiet_tx", {7'b0, tx}, 8'd1);
      chk("quiet_busy", {7'b0, busy}, 8'd0);
      chk("quiet_ovf", {7'b0, overflow}, 8'd0);
    end
    $display("quiet period done");

    // Table of single isolated frames.
    foreach (vecs[i]) begin
      do_write(vecs[i].data);
      chk("vec_busy_rise", {7'b0, busy}, 8'd1);
      frame(vecs[i].data, vecs[i].par);
      chk("vec_busy_fall", {7'b0, busy}, 8'd0);
      chk("vec_tx_idle", {7'b0, tx}, 8'd1);
    end

    // Six writes on consecutive edges: fifth fills, sixth overflows.
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i + 1);
      tick();
      chk("burst_full", {7'b0, wr_full}, (i >= 4) ? 8'd1 : 8'd0);
      chk("burst_ovf", {7'b0, overflow}, (i == 5) ? 8'd1 : 8'd0);
      if (i == 0) chk("burst_tx", {7'b0, tx}, 8'd1);
      else if (i < 5) chk("burst_tx", {7'b0, tx}, 8'd0);
      $display("burst write 0x%02h: wr_full=%0b overflow=%0b", 8'(i + 1), wr_full, overflow);
    end
    wr_valid = 1'b0;
    frame_body(8'h01, 1'b1, 4, -1, 8'h00);
    frame(8'h02, 1'b1);
    frame(8'h03, 1'b0);
    frame(8'h04, 1'b1);
    frame(8'h05, 1'b0);
    chk("burst_end_busy", {7'b0, busy}, 8'd0);
    chk("burst_end_ovf", {7'b0, overflow}, 8'd1);
    chk("burst_end_full", {7'b0, wr_full}, 8'd0);

    // Write arriving mid-frame must not disturb the frame in flight.
    do_write(8'h00);
    chk("mid_tx_pre", {7'b0, tx}, 8'd1);
    tick();
    frame_body(8'h00, 1'b0, 0, 12, 8'hFF);
    frame(8'hFF, 1'b0);
    chk("mid_busy_end", {7'b0, busy}, 8'd0);

    // Asynchronous reset during the data phase of 0x3C.
    do_write(8'h3C);
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("pre_reset_tx", {7'b0, tx}, 8'd0);
    chk("pre_reset_busy", {7'b0, busy}, 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_tx", {7'b0, tx}, 8'd1);
    chk("async_rst_busy", {7'b0, busy}, 8'd0);
    chk("async_rst_ovf", {7'b0, overflow}, 8'd0);
    chk("async_rst_full", {7'b0, wr_full}, 8'd0);
    $display("reset asserted mid-frame: tx=%0b busy=%0b", tx, busy);
    @(posedge clk);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_tx", {7'b0, tx}, 8'd1);
      chk("post_rst_busy", {7'b0, busy}, 8'd0);
    end
    do_write(8'h81);
    frame(8'h81, 1'b0);
    chk("post_rst_done", {7'b0, busy}, 8'd0);
    chk("post_rst_ovf", {7'b0, overflow}, 8'd0);

    // Fill the FIFO behind a frame, then write on the very edge IDLE pops.
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'((i + 1) * 8'h11);
      tick();
      if (i == 0) chk("fill_tx", {7'b0, tx}, 8'd1);
      else chk("fill_tx", {7'b0, tx}, 8'd0);
    end
    wr_valid = 1'b0;
    chk("fill_full", {7'b0, wr_full}, 8'd1);
    frame_body(8'h11, 1'b0, 3, -1, 8'h00);
    chk("pop_edge_tx", {7'b0, tx}, 8'd1);
    chk("pop_edge_full", {7'b0, wr_full}, 8'd1);
    chk("pop_edge_ovf", {7'b0, overflow}, 8'd0);
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    tick();
    wr_valid = 1'b0;
    chk("drop_ovf", {7'b0, overflow}, 8'd1);
    chk("drop_count_dec", {7'b0, wr_full}, 8'd0);
    $display("write 0x99 on pop edge: overflow=%0b wr_full=%0b", overflow, wr_full);
    frame_body(8'h22, 1'b0, 0, -1, 8'h00);
    frame(8'h33, 1'b0);
    frame(8'h44, 1'b0);
    frame(8'h55, 1'b0);
    chk("drop_end_busy", {7'b0, busy}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("drop_end_tx", {7'b0, tx}, 8'd1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tiny_cpu_uart_tx.md
# tiny_cpu_uart_tx

Serial output stage placed directly downstream of the tiny CPU core's 8-bit output port. Each value the CPU writes to output address 31 is queued in a small FIFO and transmitted as an 8N1 UART frame, LSB first, on a single pin. This lets a bench or host capture the CPU's output stream without sampling the parallel output bus. Frame timing is derived from the system clock by a programmable bit-period counter.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit. Must be ≥ 2. The counter is 16 bits wide.
- `FIFO_DEPTH`, default 4: number of entries in the byte queue. Must be a power of two, ≥ 2.
- `clk`  in  1: system clock, the same clock as the CPU core.
- `reset`  in  1: asynchronous, active-high reset.
- `wr_valid`  in  1: one-cycle strobe. The integrator asserts it in the CPU execute cycle of `STA 31`.
- `wr_data`  in  8: byte to queue, which is the CPU accumulator value. It is sampled only when `wr_valid`=1.
- `wr_full`  out  1: the FIFO holds `FIFO_DEPTH` entries.
- `tx`  out  1: UART serial line. It idles high.
- `busy`  out  1: high when the FSM is not in IDLE or the FIFO is not empty.
- `overflow`  out  1: sticky flag. It is set when a write is dropped.

## Operation
- FIFO write rules:
  - When `wr_valid`=1 and `wr_full`=0, `wr_data` is stored at the write pointer. The write pointer and the count both increment.
  - When `wr_valid`=1 and `wr_full`=1, the write is dropped and `overflow` is set to 1. This applies even if a pop occurs in the same cycle; `wr_full` is evaluated on the pre-edge count.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally. The count is log2(`FIFO_DEPTH`)+1 bits wide.
- FSM states are IDLE, START, DATA, PARITY (present only when the macro is defined) and STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the bit counter and the baud counter, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=shift[0]. After each `CLKS_PER_BIT` cycles, shift right and increment the 3-bit index. After index 7 completes, go to PARITY if it is compiled in, otherwise to STOP.
  - PARITY: `tx`=XOR of the 8 popped data bits (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- The baud counter counts 0..`CLKS_PER_BIT`-1. The bit period ends on the cycle the counter equals `CLKS_PER_BIT`-1, and the counter wraps to 0.
- `overflow` is cleared only by `reset`.

## Timing
- Reset values: `tx`=1, `busy`=0, `wr_full`=0, `overflow`=0. FIFO is empty, FSM is in IDLE, all counters are 0.
- `tx` is driven from a flop, so there is no combinational path from any input.
- Write latency:
  - A write accepted at edge E makes the FIFO non-empty after E.
  - The IDLE pop happens at edge E+1, and `tx` falls after E+1.
- Frame length is 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` cycles with parity.
- Back-to-back frames: IDLE lasts exactly one cycle between the end of STOP and the next START when the FIFO is non-empty.
- `busy` rises after the accepting edge E. It falls after the edge on which STOP completes with the FIFO empty.
- `wr_full` and `overflow` update on the same edge as the triggering write.
- Reset asserted mid-frame:
  - `tx` goes to 1 immediately (asynchronous), the FIFO empties, and any partial frame is abandoned.
  - After deassertion, no transmission occurs until a new write.

## Configuration
- `TINYCPU_UART_PARITY_EN`:
  - Defined: the PARITY state is compiled in, and frames are 8E1 (11 bits).
  - Undefined: the PARITY state and its XOR logic are absent, and frames are 8N1 (10 bits).
  - All other behaviour is identical in both builds.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset, then hold for 50 cycles with no writes -> `tx`=1, `busy`=0, `overflow`=0 throughout.
- Single write 0xA5 at edge E -> `tx` falls after E+1. Bits, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1. With the macro defined, parity 0 is inserted before the stop bit. `busy` falls 40 cycles (or 44 with parity) after E+1.
- Six writes 0x01..0x06 on consecutive edges E..E+5:
  - `wr_full`=1 after E+4.
  - 0x06 is dropped and `overflow`=1 after E+5.
  - Frames 0x01..0x05 are transmitted in order with one idle cycle between frames.
- Write 0x00, then write 0xFF mid-frame -> 0x00 completes intact, then 0xFF follows. With the macro defined, parity is 0 for both frames.
- Assert `reset` during DATA of frame 0x3C -> `tx`=1 immediately and `busy`=0. After release, `tx` stays 1 until a new write 0x81 arrives, and that frame is sent correctly.
- Write while full with a pop on the same edge -> the write is dropped, `overflow`=1, and the count decrements by 1.
